// File: rtl/audio_pkt_pkg.sv
// Shared types and constants for the audio sample packetiser.
package audio_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR_H,
    ST_HDR_L,
    ST_DAT_H,
    ST_DAT_L,
    ST_DONE
  } state_e;

  localparam int HDR_BYTES = 2;

  function automatic logic [15:0] calc_tx_len(input int pkt_samples);
    return 16'(HDR_BYTES + 2 * pkt_samples);
  endfunction

endpackage

// File: rtl/audio_pkt_bank_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks; address = {bank, ptr}.
module audio_pkt_bank_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; bank_full gates every read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/audio_pkt_packer.sv
// Ping-pong packer: fills one bank with samples while the other streams out as
// a big-endian UDP payload {seq_num, samples}.
module audio_pkt_packer import audio_pkt_pkg::*; #(
  parameter  int PKT_SAMPLES = 256,
  parameter  int DATA_WIDTH  = 16,
  localparam int ADDR_W      = $clog2(PKT_SAMPLES)
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        smp_vld,
  input  logic [15:0] smp_data,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [15:0] tx_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [15:0] seq_num,
  output logic [15:0] drop_cnt,
  output logic        overflow,
  input  logic        ovf_clr
);

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("audio_pkt_packer: DATA_WIDTH must be 16");
  end
  if (PKT_SAMPLES < 4 || (PKT_SAMPLES & (PKT_SAMPLES - 1)) != 0) begin : g_bad_pkt
    $error("audio_pkt_packer: PKT_SAMPLES must be a power of two >= 4");
  end

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(PKT_SAMPLES - 1);

  state_e            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic              ram_we;
  logic              wr_fill;
  logic              smp_drop;
  logic [15:0]       rd_data;

  assign tx_len   = calc_tx_len(PKT_SAMPLES);
  assign seq_num  = seq_q;
  assign drop_cnt = drop_q;
  assign overflow = ovf_q;

  // Write side: the drop decision uses the registered full flag, so a bank
  // released by DONE in this same cycle still rejects the sample.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;
    ram_we    = 1'b0;
    wr_fill   = 1'b0;
    smp_drop  = smp_vld && bank_full_q[wr_bank_q];
    if (smp_vld && !bank_full_q[wr_bank_q]) begin
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == LAST_PTR) begin
        wr_fill   = 1'b1;
        wr_bank_d = ~wr_bank_q;
      end
    end
    if (ovf_clr) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (smp_drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_ptr_d    = rd_ptr_q;
    seq_d       = seq_q;
    bank_full_d = bank_full_q;
    tx_req      = 1'b0;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    tx_data     = '0;
    unique case (state_q)
      ST_IDLE: if (bank_full_q[rd_bank_q]) state_d = ST_REQ;
      ST_REQ: begin
        tx_req = 1'b1;
        if (tx_ack) state_d = ST_HDR_H;
      end
      ST_HDR_H: begin
        tx_valid = 1'b1;
        tx_data  = seq_q[15:8];
        if (tx_ready) state_d = ST_HDR_L;
      end
      ST_HDR_L: begin
        tx_valid = 1'b1;
        tx_data  = seq_q[7:0];
        if (tx_ready) state_d = ST_DAT_H;
      end
      ST_DAT_H: begin
        tx_valid = 1'b1;
        tx_data  = rd_data[15:8];
        if (tx_ready) state_d = ST_DAT_L;
      end
      ST_DAT_L: begin
        tx_valid = 1'b1;
        tx_data  = rd_data[7:0];
        tx_last  = (rd_ptr_q == LAST_PTR);
        if (tx_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = (rd_ptr_q == LAST_PTR) ? ST_DONE : ST_DAT_H;
        end
      end
      ST_DONE: begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d = ~rd_bank_q;
        seq_d     = seq_q + 16'd1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (wr_fill) bank_full_d[wr_bank_q] = 1'b1;
  end

  // Read address follows the next pointer, so the RAM output always holds the
  // sample at rd_ptr_q; advancing in DAT_L prefetches the next one bubble-free.
  audio_pkt_bank_ram #(
    .DEPTH (2 * PKT_SAMPLES),
    .AW    (ADDR_W + 1),
    .DW    (16)
  ) u_ram (
    .clk_i     (sys_clk),
    .we_i      (ram_we),
    .wr_addr_i ({wr_bank_q, wr_ptr_q}),
    .wr_data_i (smp_data),
    .rd_addr_i ({rd_bank_d, rd_ptr_d}),
    .rd_data_o (rd_data)
  );

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      bank_full_q <= 2'b00;
      seq_q       <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      bank_full_q <= bank_full_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_audio_pkt_packer.sv
// Self-checking bench for audio_pkt_packer with PKT_SAMPLES=4 and a packet-level model.
module tb_audio_pkt_packer;

  localparam int PKT = 4;
  localparam int NB  = 2 + 2 * PKT;

  logic        sys_clk = 1'b0;
  logic        sys_rst, smp_vld, tx_ack, tx_ready, ovf_clr;
  logic [15:0] smp_data;
  logic        tx_req, tx_valid, tx_last, overflow;
  logic [7:0]  tx_data;
  logic [15:0] tx_len, seq_num, drop_cnt;

  int total = 0;
  int bad   = 0;

  // Model: packets drain in order, so the write bank is full exactly when two
  // complete packets are waiting.
  logic [15:0] m_seq;
  logic [15:0] m_fill[$];
  logic [15:0] m_full[$];
  int          m_drop;
  bit          m_ovf;

  logic [7:0]  rx_bytes[$];
  int          rx_last_cnt, rx_last_pos, rx_unstable;
  bit          rx_timeout, rx_ack_lat_ok;

  audio_pkt_packer #(.PKT_SAMPLES(PKT)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .smp_vld  (smp_vld),
    .smp_data (smp_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .tx_len   (tx_len),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .seq_num  (seq_num),
    .drop_cnt (drop_cnt),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void model_reset();
    m_seq = '0;
    m_fill.delete();
    m_full.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_sample(input logic [15:0] d, input bit clr);
    if (m_full.size() == 2 * PKT) begin
      if (!clr) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end else begin
      m_fill.push_back(d);
      if (m_fill.size() == PKT) begin
        foreach (m_fill[i]) m_full.push_back(m_fill[i]);
        m_fill.delete();
      end
    end
    if (clr) begin
      m_drop = 0;
      m_ovf  = 1'b0;
    end
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    logic [15:0] s;
    if (i == 0) return m_seq[15:8];
    if (i == 1) return m_seq[7:0];
    s = m_full[(i - 2) / 2];
    return (i % 2 == 0) ? s[15:8] : s[7:0];
  endfunction

  function automatic void model_retire();
    repeat (PKT) void'(m_full.pop_front());
    m_seq = m_seq + 16'd1;
  endfunction

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic send_sample(input logic [15:0] d, input bit clr = 1'b0);
    smp_vld  = 1'b1;
    smp_data = d;
    ovf_clr  = clr;
    model_sample(d, clr);
    @(negedge sys_clk);
    smp_vld = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1-0-1, 2: random ready.
  task automatic receive_packet(input int mode);
    int          cyc;
    bit          stalled, r;
    logic [7:0]  held;
    rx_bytes.delete();
    rx_last_cnt   = 0;
    rx_last_pos   = -1;
    rx_unstable   = 0;
    rx_timeout    = 1'b0;
    rx_ack_lat_ok = 1'b0;
    cyc = 0;
    while (!tx_req && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
    end
    if (!tx_req) begin
      rx_timeout = 1'b1;
      return;
    end
    tx_ack = 1'b1;
    @(negedge sys_clk);
    tx_ack = 1'b0;
    rx_ack_lat_ok = tx_valid && !tx_req;
    stalled = 1'b0;
    held    = '0;
    cyc     = 0;
    while (rx_bytes.size() < NB && cyc < 200) begin
      if (stalled && (!tx_valid || tx_data !== held)) rx_unstable++;
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_ready = r;
      if (tx_valid && r) begin
        rx_bytes.push_back(tx_data);
        if (tx_last) begin
          rx_last_cnt++;
          rx_last_pos = rx_bytes.size();
        end
      end
      stalled = tx_valid && !r;
      held    = tx_data;
      @(negedge sys_clk);
      cyc++;
    end
    tx_ready = 1'b0;
    if (rx_bytes.size() < NB) rx_timeout = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; smp_vld = 1'b0; smp_data = '0;
    tx_ack = 1'b0; tx_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) tick();
    total += 8;
    if (tx_req !== 1'b0)      begin bad++; $display("FAIL rst_tx_req got=%0b exp=0", tx_req); end
    if (tx_valid !== 1'b0)    begin bad++; $display("FAIL rst_tx_valid got=%0b exp=0", tx_valid); end
    if (tx_last !== 1'b0)     begin bad++; $display("FAIL rst_tx_last got=%0b exp=0", tx_last); end
    if (tx_data !== 8'h00)    begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    if (seq_num !== 16'h0)    begin bad++; $display("FAIL rst_seq got=%h exp=0000", seq_num); end
    if (drop_cnt !== 16'h0)   begin bad++; $display("FAIL rst_drop got=%h exp=0000", drop_cnt); end
    if (overflow !== 1'b0)    begin bad++; $display("FAIL rst_ovf got=%0b exp=0", overflow); end
    if (tx_len !== 16'(NB))   begin bad++; $display("FAIL rst_tx_len got=%0d exp=%0d", tx_len, NB); end
    sys_rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < PKT; i++) send_sample(16'(16'h1111 * (i + 1)));
    total++;
    if (tx_req !== 1'b0) begin bad++; $display("FAIL basic_req_early got=%0b exp=0", tx_req); end
    tick();
    total++;
    if (tx_req !== 1'b1) begin bad++; $display("FAIL basic_req_latency got=%0b exp=1", tx_req); end
    receive_packet(0);
    total += 4;
    if (rx_timeout)        begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    if (!rx_ack_lat_ok)    begin bad++; $display("FAIL basic_ack_latency got=0 exp=1"); end
    if (rx_last_cnt != 1)  begin bad++; $display("FAIL basic_last_count got=%0d exp=1", rx_last_cnt); end
    if (rx_last_pos != NB) begin bad++; $display("FAIL basic_last_pos got=%0d exp=%0d", rx_last_pos, NB); end
    if (rx_bytes.size() == NB)
      for (int i = 0; i < NB; i++) begin
        total++;
        if (rx_bytes[i] !== exp_byte(i)) begin
          bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, rx_bytes[i], exp_byte(i));
        end
      end
    model_retire();
    tick();
    total++;
    if (seq_num !== m_seq) begin bad++; $display("FAIL basic_seq got=%h exp=%h", seq_num, m_seq); end
  endtask

  task automatic test_ready_patterns();
    for (int mode = 1; mode <= 2; mode++)
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < PKT; i++) send_sample(16'($urandom));
        receive_packet(mode);
        total += 3;
        if (rx_timeout)        begin bad++; $display("FAIL ready_m%0d_timeout got=1 exp=0", mode); end
        if (rx_unstable != 0)  begin bad++; $display("FAIL ready_m%0d_stable got=%0d exp=0", mode, rx_unstable); end
        if (rx_last_pos != NB) begin bad++; $display("FAIL ready_m%0d_last got=%0d exp=%0d", mode, rx_last_pos, NB); end
        if (rx_bytes.size() == NB)
          for (int i = 0; i < NB; i++) begin
            total++;
            if (rx_bytes[i] !== exp_byte(i)) begin
              bad++; $display("FAIL ready_m%0d_byte%0d got=%h exp=%h", mode, i, rx_bytes[i], exp_byte(i));
            end
          end
        model_retire();
        tick();
        total++;
        if (seq_num !== m_seq) begin bad++; $display("FAIL ready_m%0d_seq got=%h exp=%h", mode, seq_num, m_seq); end
      end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < PKT; i++) send_sample(16'($urandom));
    fork
      receive_packet(2);
      for (int i = 0; i < PKT; i++) begin
        send_sample(16'($urandom));
        tick();
      end
    join
    for (int p = 0; p < 2; p++) begin
      if (p == 1) receive_packet(0);
      total++;
      if (rx_timeout) begin bad++; $display("FAIL b2b_p%0d_timeout got=1 exp=0", p); end
      if (rx_bytes.size() == NB)
        for (int i = 0; i < NB; i++) begin
          total++;
          if (rx_bytes[i] !== exp_byte(i)) begin
            bad++; $display("FAIL b2b_p%0d_byte%0d got=%h exp=%h", p, i, rx_bytes[i], exp_byte(i));
          end
        end
      model_retire();
      tick();
    end
    total++;
    if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, m_drop); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3 * PKT; i++) send_sample(16'($urandom));
    total += 2;
    if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_cnt, m_drop); end
    if (overflow !== m_ovf)       begin bad++; $display("FAIL ovf_flag got=%0b exp=%0b", overflow, m_ovf); end
    for (int p = 0; p < 2; p++) begin
      receive_packet(0);
      total++;
      if (rx_timeout) begin bad++; $display("FAIL ovf_p%0d_timeout got=1 exp=0", p); end
      if (rx_bytes.size() == NB)
        for (int i = 0; i < NB; i++) begin
          total++;
          if (rx_bytes[i] !== exp_byte(i)) begin
            bad++; $display("FAIL ovf_p%0d_byte%0d got=%h exp=%h", p, i, rx_bytes[i], exp_byte(i));
          end
        end
      model_retire();
      tick();
    end
  endtask

  task automatic test_ovf_clr_race();
    for (int i = 0; i < 2 * PKT; i++) send_sample(16'($urandom));
    send_sample(16'($urandom), 1'b1);
    total += 2;
    if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL clr_race_drop got=%0d exp=%0d", drop_cnt, m_drop); end
    if (overflow !== m_ovf)       begin bad++; $display("FAIL clr_race_ovf got=%0b exp=%0b", overflow, m_ovf); end
    send_sample(16'($urandom));
    total += 2;
    if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL clr_next_drop got=%0d exp=%0d", drop_cnt, m_drop); end
    if (overflow !== m_ovf)       begin bad++; $display("FAIL clr_next_ovf got=%0b exp=%0b", overflow, m_ovf); end
    for (int p = 0; p < 2; p++) begin
      receive_packet(0);
      total++;
      if (rx_timeout) begin bad++; $display("FAIL clr_p%0d_timeout got=1 exp=0", p); end
      model_retire();
      tick();
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    m_drop = 0;
    m_ovf  = 1'b0;
    total++;
    if (overflow !== m_ovf) begin bad++; $display("FAIL clr_only_ovf got=%0b exp=%0b", overflow, m_ovf); end
  endtask

  task automatic test_seq_wrap();
    force dut.seq_q = 16'hFFFF;
    repeat (2) tick();
    release dut.seq_q;
    m_seq = 16'hFFFF;
    tick();
    total++;
    if (seq_num !== m_seq) begin bad++; $display("FAIL wrap_preload got=%h exp=%h", seq_num, m_seq); end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < PKT; i++) send_sample(16'($urandom));
      receive_packet(0);
      total++;
      if (rx_timeout) begin bad++; $display("FAIL wrap_p%0d_timeout got=1 exp=0", p); end
      if (rx_bytes.size() == NB)
        for (int i = 0; i < NB; i++) begin
          total++;
          if (rx_bytes[i] !== exp_byte(i)) begin
            bad++; $display("FAIL wrap_p%0d_byte%0d got=%h exp=%h", p, i, rx_bytes[i], exp_byte(i));
          end
        end
      model_retire();
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < PKT; i++) send_sample(16'($urandom));
    cyc = 0;
    while (!tx_req && cyc < 20) begin tick(); cyc++; end
    total++;
    if (tx_req !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%0b exp=1", tx_req); end
    tx_ack = 1'b1;
    tick();
    tx_ack   = 1'b0;
    tx_ready = 1'b1;
    repeat (2) tick();
    tx_ready = 1'b0;
    repeat (2) tick();
    total += 2;
    if (tx_valid !== 1'b1) begin bad++; $display("FAIL rstmid_stall_valid got=%0b exp=1", tx_valid); end
    if (tx_data !== m_full[0][15:8]) begin
      bad++; $display("FAIL rstmid_stall_data got=%h exp=%h", tx_data, m_full[0][15:8]);
    end
    #2 sys_rst = 1'b1;
    #1;
    total += 3;
    if (tx_valid !== 1'b0)         begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", tx_valid); end
    if (tx_req !== 1'b0)           begin bad++; $display("FAIL rstmid_req_low got=%0b exp=0", tx_req); end
    if (dut.bank_full_q !== 2'b00) begin bad++; $display("FAIL rstmid_full got=%b exp=00", dut.bank_full_q); end
    tick();
    sys_rst = 1'b0;
    model_reset();
    tick();
    for (int i = 0; i < PKT; i++) send_sample(16'($urandom));
    receive_packet(0);
    total++;
    if (rx_timeout) begin bad++; $display("FAIL rstmid_after_timeout got=1 exp=0"); end
    if (rx_bytes.size() == NB)
      for (int i = 0; i < NB; i++) begin
        total++;
        if (rx_bytes[i] !== exp_byte(i)) begin
          bad++; $display("FAIL rstmid_after_byte%0d got=%h exp=%h", i, rx_bytes[i], exp_byte(i));
        end
      end
    model_retire();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_patterns();
    test_back_to_back();
    test_overflow();
    test_ovf_clr_race();
    test_seq_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
